// File: rtl/sorted_result_streamer.sv
// Streams the sorted RAM contents out on a valid/ready interface, index 0 first,
// and flags any accepted word that is smaller than its predecessor.
module sorted_result_streamer #(
   parameter int unsigned SIZE       = 4,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_last,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  order_error
);

   // One extra index bit so SIZE == 2**ADDR_WIDTH never overflows the compare.
   localparam int unsigned IDX_W = ADDR_WIDTH + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   prev_q, prev_d;
   logic [IDX_W-1:0]        idx_next;
   logic                    accept;

   // Next-state, datapath and read-address decode.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      err_d       = err_q;
      prev_d      = prev_q;
      rd_addr     = ADDR_WIDTH'(0);
      idx_next    = idx_q + IDX_W'(1);
      accept      = out_valid_q & out_ready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            rd_addr     = idx_q[ADDR_WIDTH-1:0];
            out_data_d  = rd_data;
            out_valid_d = 1'b1;
            out_last_d  = (idx_q == LAST_IDX);
            state_d     = S_SEND;
         end
         S_SEND: begin
            // Prefetch the following word so a beat can be replaced every cycle.
            rd_addr = idx_next[ADDR_WIDTH-1:0];
            if (accept) begin
               if ((idx_q != '0) && (out_data_q < prev_q)) begin
                  err_d = 1'b1;
               end
               prev_d = out_data_q;
               if (idx_q < LAST_IDX) begin
                  idx_d      = idx_next;
                  out_data_d = rd_data;
                  out_last_d = (idx_next == LAST_IDX);
               end else begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  done_d      = 1'b1;
                  state_d     = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         prev_q      <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         prev_q      <= prev_d;
      end
   end

   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign order_error = err_q;

endmodule

// File: tb/tb_sorted_result_streamer.sv
// Directed and randomized bench for sorted_result_streamer against a queue-free
// reference: the expected stream is simply the RAM array in index order.
module tb_sorted_result_streamer;

   localparam int unsigned SIZE = 4;
   localparam int unsigned AW   = 2;
   localparam int unsigned DW   = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_last;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic          order_error;

   logic [DW-1:0] ram [SIZE];
   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   assign rd_data = ram[rd_addr];

   sorted_result_streamer #(.SIZE(SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
      .busy(busy), .done(done), .order_error(order_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Expected error after k accepted beats: any descent within the first k words.
   function automatic logic exp_err(input int k);
      for (int j = 1; j < k; j++) begin
         if (ram[AW'(j)] < ram[AW'(j - 1)]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic set_ram(input int a, input int b, input int c, input int d);
      ram[0] = DW'(a); ram[1] = DW'(b); ram[2] = DW'(c); ram[3] = DW'(d);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_valid"}, 32'(out_valid), 0);
      chk({tag, "_last"},  32'(out_last), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_data"},  32'(out_data), 0);
      chk({tag, "_err"},   32'(order_error), 0);
   endtask

   // mode 1: ready high, 2: fixed toggle pattern, 3: random ready,
   // 4: ready high plus stray starts in SEND and DONE. abort_after>0 resets mid-stream.
   task automatic run_stream(input int mode, input int abort_after);
      int   beats = 0;
      int   cyc   = 0;
      logic rdy;
      int   pat [7] = '{1, 0, 0, 1, 0, 1, 1};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("load_busy",  32'(busy), 1);
      chk("load_valid", 32'(out_valid), 0);
      chk("load_err",   32'(order_error), 0);
      while (beats < int'(SIZE) && cyc < 60) begin
         @(negedge clk); cyc++;
         if (abort_after > 0 && beats == abort_after) begin
            reset = 1'b1; start = 1'b1;
            @(negedge clk);
            reset = 1'b0; start = 1'b0;
            chk_all_zero("abort");
            @(negedge clk);
            chk("abort_stay_idle", 32'(busy), 0);
            return;
         end
         case (mode)
            2:       rdy = (pat[(cyc - 1) % 7] != 0);
            3:       rdy = 1'($urandom_range(0, 1));
            default: rdy = 1'b1;
         endcase
         out_ready = rdy;
         start = (mode == 4 && cyc == 2);
         chk("beat_valid", 32'(out_valid), 1);
         chk("beat_data",  32'(out_data), 32'(ram[AW'(beats)]));
         chk("beat_last",  32'(out_last), 32'(beats == int'(SIZE) - 1));
         chk("beat_done",  32'(done), 0);
         chk("beat_err",   32'(order_error), 32'(exp_err(beats)));
         if (rdy) beats++;
      end
      if (cyc >= 60) chk("stream_timeout", 32'(beats), SIZE);
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      start = (mode == 4);
      chk("done_pulse", 32'(done), 1);
      chk("done_busy",  32'(busy), 1);
      chk("done_valid", 32'(out_valid), 0);
      chk("done_last",  32'(out_last), 0);
      chk("done_err",   32'(order_error), 32'(exp_err(SIZE)));
      @(negedge clk);
      start = 1'b0;
      chk("post_done", 32'(done), 0);
      chk("post_busy", 32'(busy), 0);
      chk("post_err",  32'(order_error), 32'(exp_err(SIZE)));
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rd_addr", 32'(rd_addr), 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; out_ready = 1'b0;
      set_ram(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_all_zero("reset");

      set_ram(3, 7, 7, 200);
      run_stream(1, 0);
      run_stream(2, 0);

      set_ram(5, 9, 2, 9);
      run_stream(1, 0);
      chk("err_sticky", 32'(order_error), 1);

      set_ram(3, 7, 7, 200);
      run_stream(2, 0);
      run_stream(4, 0);

      set_ram(10, 20, 30, 40);
      run_stream(1, 2);
      run_stream(1, 0);

      set_ram(0, 0, 255, 255);
      run_stream(1, 0);
      set_ram(255, 0, 0, 255);
      run_stream(3, 0);

      for (int it = 0; it < 20; it++) begin
         for (int j = 0; j < int'(SIZE); j++) ram[AW'(j)] = DW'($urandom);
         if (it % 2 == 0) begin
            for (int a = 0; a < int'(SIZE); a++)
               for (int b = 0; b < int'(SIZE) - 1 - a; b++)
                  if (ram[AW'(b)] > ram[AW'(b + 1)]) begin
                     logic [DW-1:0] t;
                     t = ram[AW'(b)]; ram[AW'(b)] = ram[AW'(b + 1)]; ram[AW'(b + 1)] = t;
                  end
         end
         run_stream(3, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
